// File: rtl/bias_pingpong_buffer_pkg.sv
// Shared CNN definitions used by the bias ping-pong buffer: default sizes and
// the load FSM state encoding.
package cnn_pkg;

  localparam int BIAS_W   = 16;
  localparam int CONV_NCH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } bias_state_e;

  // Channel-counter width; never below one bit so tiny layers still index.
  function automatic int cnt_width(input int n_ch);
    int w;
    if (n_ch > 1) begin
      w = $clog2(n_ch);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bias_pingpong_buffer_if.sv
// Load stream, swap/read control and flat bias vector between the
// weight/bias loader, the buffer and the conv engine.
interface bias_pingpong_buffer_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = BIAS_W,
  parameter int N_CH   = CONV_NCH
) ();

  logic                     load_en;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     done_bias;
  logic                     swap;
  logic                     r_en;
  logic [DATA_W*N_CH-1:0]   bias_out;
  logic                     bias_valid;
  logic                     rd_bank;
  logic                     err_ovf;

  modport master (
    output load_en, in_valid, in_data, swap, r_en,
    input  in_ready, done_bias, bias_out, bias_valid, rd_bank, err_ovf
  );

  modport slave (
    input  load_en, in_valid, in_data, swap, r_en,
    output in_ready, done_bias, bias_out, bias_valid, rd_bank, err_ovf
  );

endinterface

// File: rtl/bias_pingpong_buffer_bank.sv
// One bias bank: N_CH words with a synchronous write port and every word
// exposed at once as a flat combinational vector.
module bias_bank
  import cnn_pkg::*;
#(
  parameter int  DATA_W = BIAS_W,
  parameter int  N_CH   = CONV_NCH,
  localparam int AW     = cnt_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W*N_CH-1:0] rd_vec
);

  for (genvar g = 0; g < N_CH; g++) begin : g_word
    logic [DATA_W-1:0] word_r;

    // Word storage: cleared on reset, written only when addressed.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_r <= '0;
      end else if (we && (waddr == AW'(g))) begin
        word_r <= wdata;
      end
    end

    assign rd_vec[g*DATA_W +: DATA_W] = word_r;
  end

endmodule

// File: rtl/bias_pingpong_buffer.sv
// Ping-pong per-channel bias store: serial load into the write bank while the
// conv engine reads the committed bank as one registered flat vector.
module bias_pingpong_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = BIAS_W,
  parameter int N_CH   = CONV_NCH
) (
  input  logic                   clk,
  input  logic                   rst,
  bias_pingpong_buffer_if.slave  bus
);

  localparam int              AW       = cnt_width(N_CH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(N_CH - 1);

  bias_state_e              state_r, state_nxt_s;
  logic [AW-1:0]            cnt_r, cnt_nxt_s;
  logic                     wr_bank_r, wr_bank_nxt_s;
  logic                     rd_bank_r, rd_bank_nxt_s;
  logic                     accept_s, err_set_s;
  logic                     we0_s, we1_s;
  logic [DATA_W*N_CH-1:0]   bank0_vec_s, bank1_vec_s;
  logic                     in_ready_r, done_bias_r, bias_valid_r, err_ovf_r;
  logic [DATA_W*N_CH-1:0]   bias_out_r;

  // Next-state, counter and bank-pointer decode for the load FSM.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    wr_bank_nxt_s = wr_bank_r;
    rd_bank_nxt_s = rd_bank_r;
    accept_s      = 1'b0;
    err_set_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.load_en) begin
          state_nxt_s = S_LOAD;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          if (cnt_r == LAST_IDX) begin
            state_nxt_s = S_FULL;
          end else begin
            cnt_nxt_s = cnt_r + AW'(1);
          end
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_FULL: begin
        err_set_s = bus.in_valid;
        if (bus.swap) begin
          rd_bank_nxt_s = wr_bank_r;
          wr_bank_nxt_s = ~wr_bank_r;
          cnt_nxt_s     = '0;
          state_nxt_s   = S_IDLE;
        end else begin
          state_nxt_s = S_FULL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign we0_s = accept_s & ~wr_bank_r;
  assign we1_s = accept_s &  wr_bank_r;

  bias_bank #(.DATA_W(DATA_W), .N_CH(N_CH)) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .we     (we0_s),
    .waddr  (cnt_r),
    .wdata  (bus.in_data),
    .rd_vec (bank0_vec_s)
  );

  bias_bank #(.DATA_W(DATA_W), .N_CH(N_CH)) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .we     (we1_s),
    .waddr  (cnt_r),
    .wdata  (bus.in_data),
    .rd_vec (bank1_vec_s)
  );

  // State, pointers, status flags and read register; read uses pre-swap rd_bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b1;
      in_ready_r   <= 1'b0;
      done_bias_r  <= 1'b0;
      bias_valid_r <= 1'b0;
      err_ovf_r    <= 1'b0;
      bias_out_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      wr_bank_r    <= wr_bank_nxt_s;
      rd_bank_r    <= rd_bank_nxt_s;
      in_ready_r   <= (state_nxt_s == S_LOAD);
      done_bias_r  <= (state_nxt_s == S_FULL);
      bias_valid_r <= bus.r_en;
      err_ovf_r    <= err_ovf_r | err_set_s;
      if (bus.r_en) begin
        bias_out_r <= rd_bank_r ? bank1_vec_s : bank0_vec_s;
      end
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.done_bias  = done_bias_r;
  assign bus.bias_valid = bias_valid_r;
  assign bus.bias_out   = bias_out_r;
  assign bus.rd_bank    = rd_bank_r;
  assign bus.err_ovf    = err_ovf_r;

endmodule

// File: tb/tb_bias_pingpong_buffer.sv
// Directed bench: 32x16 instance driven by hand sequences, 4x8 instance by a
// per-cycle vector table.
module tb_bias_pingpong_buffer;
  import cnn_pkg::*;

  localparam int BW = 16;
  localparam int BN = 32;
  localparam int SW = 8;
  localparam int SN = 4;

  logic clk = 1'b0;
  logic rst_big;
  logic rst_small;
  always #5 clk = ~clk;

  bias_pingpong_buffer_if #(.DATA_W(BW), .N_CH(BN)) bif ();
  bias_pingpong_buffer_if #(.DATA_W(SW), .N_CH(SN)) sif ();

  bias_pingpong_buffer #(.DATA_W(BW), .N_CH(BN)) u_big (
    .clk (clk), .rst (rst_big), .bus (bif.slave)
  );
  bias_pingpong_buffer #(.DATA_W(SW), .N_CH(SN)) u_small (
    .clk (clk), .rst (rst_small), .bus (sif.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        load_en, in_valid, swap, r_en;
    logic [7:0]  data;
    logic        e_ready, e_done, e_bv, e_rdb, e_err;
    logic [31:0] e_out;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 512'(act), 512'(exp));
  endtask

  function automatic logic [BW*BN-1:0] set_vec(input logic [15:0] base);
    logic [BW*BN-1:0] v;
    for (int i = 0; i < BN; i++) v[i*BW +: BW] = base + 16'(i);
    return v;
  endfunction

  function automatic vec_t mk(input logic le, input logic iv, input logic sw, input logic re,
                              input logic [7:0] d, input logic rdy, input logic dn,
                              input logic bv, input logic rb, input logic er, input logic [31:0] o);
    vec_t v;
    v.load_en = le; v.in_valid = iv; v.swap = sw; v.r_en = re; v.data = d;
    v.e_ready = rdy; v.e_done = dn; v.e_bv = bv; v.e_rdb = rb; v.e_err = er; v.e_out = o;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bif.load_en = 1'b1;
    tick();
    bif.load_en = 1'b0;
    chk1("load_ready", bif.in_ready, 1'b1);
  endtask

  task automatic do_swap();
    bif.swap = 1'b1;
    tick();
    bif.swap = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [BW*BN-1:0] exp);
    bif.r_en = 1'b1;
    tick();
    bif.r_en = 1'b0;
    chk1({name, "_valid"}, bif.bias_valid, 1'b1);
    chk({name, "_data"}, 512'(bif.bias_out), 512'(exp));
    tick();
    chk1({name, "_valid_drop"}, bif.bias_valid, 1'b0);
  endtask

  // Streams nbeats words base+i; optional ~50% gaps and a read every 4 cycles.
  task automatic stream(input logic [15:0] base, input int nbeats, input bit gaps,
                        input bit rd_poll, input logic [15:0] rd_base, output int rdy_cycles);
    int   i = 0;
    int   budget = 0;
    logic rdy, ren;
    rdy_cycles = 0;
    while (i < nbeats && budget < 1000) begin
      bif.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.in_data  = base + 16'(i);
      ren          = rd_poll && ((budget % 4) == 0);
      bif.r_en     = ren;
      rdy          = bif.in_ready;
      tick();
      if (rdy) rdy_cycles++;
      if (rdy && bif.in_valid) i++;
      if (ren) begin
        chk1("poll_valid", bif.bias_valid, 1'b1);
        chk("poll_data", 512'(bif.bias_out), 512'(set_vec(rd_base)));
      end
      budget++;
    end
    bif.in_valid = 1'b0;
    bif.r_en     = 1'b0;
    chk("stream_beats", 512'(i), 512'(nbeats));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc;
    bif.load_en = 1'b0; bif.in_valid = 1'b0; bif.in_data = '0; bif.swap = 1'b0; bif.r_en = 1'b0;
    sif.load_en = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0; sif.swap = 1'b0; sif.r_en = 1'b0;
    rst_big = 1'b1;
    rst_small = 1'b1;
    repeat (2) tick();
    chk("reset_flags", 512'({bif.in_ready, bif.done_bias, bif.bias_valid, bif.err_ovf}), 512'(4'b0000));
    chk1("reset_rd_bank", bif.rd_bank, 1'b1);
    chk("reset_bias_out", 512'(bif.bias_out), 512'(0));
    rst_big = 1'b0;
    rst_small = 1'b0;
    tick();
    chk1("idle_ready", bif.in_ready, 1'b0);

    // Full load with in_valid held high.
    start_load();
    stream(16'h0100, BN, 1'b0, 1'b0, 16'h0000, rc);
    chk("ready_cycles", 512'(rc), 512'(BN));
    chk1("done_after_31", bif.done_bias, 1'b1);
    chk1("full_not_ready", bif.in_ready, 1'b0);
    tick();
    chk1("done_level", bif.done_bias, 1'b1);

    // Commit and read back.
    do_swap();
    chk1("swap1_rd_bank", bif.rd_bank, 1'b0);
    chk1("swap1_done_clr", bif.done_bias, 1'b0);
    do_read("read_set1", set_vec(16'h0100));

    // Second set loads while the first is polled.
    start_load();
    stream(16'h0200, BN, 1'b0, 1'b1, 16'h0100, rc);
    chk1("set2_done", bif.done_bias, 1'b1);
    do_read("read_pre_swap", set_vec(16'h0100));
    do_swap();
    chk1("swap2_rd_bank", bif.rd_bank, 1'b1);
    do_read("read_set2", set_vec(16'h0200));

    // Fresh reset, then a gappy load must give the same contents.
    rst_big = 1'b1;
    tick();
    rst_big = 1'b0;
    start_load();
    stream(16'h0100, BN, 1'b1, 1'b0, 16'h0000, rc);
    chk1("gap_done", bif.done_bias, 1'b1);
    do_swap();
    chk1("gap_rd_bank", bif.rd_bank, 1'b0);
    do_read("read_gap", set_vec(16'h0100));

    // Overflow while FULL: sticky flag, word dropped.
    start_load();
    stream(16'h0300, BN, 1'b0, 1'b0, 16'h0000, rc);
    bif.in_valid = 1'b1;
    bif.in_data  = 16'hDEAD;
    tick();
    bif.in_valid = 1'b0;
    chk1("ovf_set", bif.err_ovf, 1'b1);
    repeat (3) tick();
    chk1("ovf_sticky", bif.err_ovf, 1'b1);
    chk1("ovf_still_full", bif.done_bias, 1'b1);
    do_swap();
    chk1("swap3_rd_bank", bif.rd_bank, 1'b1);
    do_read("read_set3", set_vec(16'h0300));
    chk1("ovf_after_swap", bif.err_ovf, 1'b1);

    // Swap ignored mid-load, then reset aborts the load.
    start_load();
    stream(16'h0500, 10, 1'b0, 1'b0, 16'h0000, rc);
    do_swap();
    chk1("swap_in_load_rd", bif.rd_bank, 1'b1);
    chk1("swap_in_load_ready", bif.in_ready, 1'b1);
    rst_big = 1'b1;
    tick();
    rst_big = 1'b0;
    chk("abort_flags", 512'({bif.in_ready, bif.done_bias, bif.err_ovf, bif.rd_bank}), 512'(4'b0001));
    do_read("read_after_rst", '0);

    // Small instance: per-cycle vectors.
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44332211);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA4A3A2A1);
    for (int r = 0; r < 19; r++) begin
      sif.load_en  = tbl[r].load_en;
      sif.in_valid = tbl[r].in_valid;
      sif.swap     = tbl[r].swap;
      sif.r_en     = tbl[r].r_en;
      sif.in_data  = tbl[r].data;
      tick();
      chk($sformatf("small_row%0d", r),
          512'({sif.in_ready, sif.done_bias, sif.bias_valid, sif.rd_bank, sif.err_ovf, sif.bias_out}),
          512'({tbl[r].e_ready, tbl[r].e_done, tbl[r].e_bv, tbl[r].e_rdb, tbl[r].e_err, tbl[r].e_out}));
    end
    sif.load_en = 1'b0; sif.in_valid = 1'b0; sif.swap = 1'b0; sif.r_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
